// File: rtl/display_scan_timer.sv
// Digit scan timer for a four-digit seven-segment display: slot/digit counter, anti-ghost blanking
// and frame-aligned value commit. Define DISPLAY_SCAN_DIM_EN to add the 3-bit brightness input.
module display_scan_timer #(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value_in,
    input  logic        value_load,
`ifdef DISPLAY_SCAN_DIM_EN
    input  logic [2:0]  brightness,
`endif
    output logic [1:0]  count2,
    output logic [15:0] count16,
    output logic        disp_en,
    output logic        frame_tick,
    output logic        value_ack,
    output logic        busy
);

    localparam int unsigned TICKS_PER_DIGIT = CLK_HZ / (REFRESH_HZ * 4);
    localparam int unsigned TW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);

    generate
        if (TICKS_PER_DIGIT < 2 || BLANK_CYCLES >= TICKS_PER_DIGIT) begin : g_bad_params
            $error("display_scan_timer: need TICKS_PER_DIGIT >= 2 and BLANK_CYCLES < TICKS_PER_DIGIT");
        end
    endgenerate

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    count2_q, count2_d;
    logic [15:0]   count16_q, count16_d;
    logic [15:0]   pend_val_q, pend_val_d;
    logic          pending_q, pending_d;
    logic          disp_en_q, disp_en_d;
    logic          frame_tick_q, frame_tick_d;
    logic          value_ack_q, value_ack_d;
    logic          slot_end;
    logic          frame_end;
    logic [31:0]   tick_next;

`ifdef DISPLAY_SCAN_DIM_EN
    localparam int unsigned ACT_UNIT = (TICKS_PER_DIGIT - BLANK_CYCLES) >> 3;
    logic [2:0]  bright_q, bright_d;
    logic [31:0] lit_end;
`endif

    always_comb begin
        slot_end     = (tick_cnt_q == TICK_LAST);
        frame_end    = slot_end && (count2_q == 2'd3);
        tick_cnt_d   = slot_end ? '0 : tick_cnt_q + TW'(1);
        count2_d     = slot_end ? count2_q + 2'd1 : count2_q;
        // A load on the boundary cycle never bypasses: the old pending value commits first.
        pend_val_d   = value_load ? value_in : pend_val_q;
        pending_d    = value_load | (pending_q & ~frame_end);
        count16_d    = (frame_end && pending_q) ? pend_val_q : count16_q;
        value_ack_d  = frame_end & pending_q;
        frame_tick_d = frame_end;
        tick_next    = 32'(tick_cnt_d);
`ifdef DISPLAY_SCAN_DIM_EN
        // Brightness takes effect from the first slot of the new frame.
        bright_d  = frame_end ? brightness : bright_q;
        lit_end   = (bright_d == 3'd7) ? TICKS_PER_DIGIT
                                       : BLANK_CYCLES + ACT_UNIT * (32'(bright_d) + 32'd1);
        disp_en_d = (tick_next >= BLANK_CYCLES) && (tick_next < lit_end);
`else
        disp_en_d = (tick_next >= BLANK_CYCLES);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_q   <= '0;
            count2_q     <= '0;
            count16_q    <= '0;
            pend_val_q   <= '0;
            pending_q    <= 1'b0;
            disp_en_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            value_ack_q  <= 1'b0;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            count2_q     <= count2_d;
            count16_q    <= count16_d;
            pend_val_q   <= pend_val_d;
            pending_q    <= pending_d;
            disp_en_q    <= disp_en_d;
            frame_tick_q <= frame_tick_d;
            value_ack_q  <= value_ack_d;
        end
    end

`ifdef DISPLAY_SCAN_DIM_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bright_q <= 3'd7;
        end else begin
            bright_q <= bright_d;
        end
    end
`endif

    assign count2     = count2_q;
    assign count16    = count16_q;
    assign disp_en    = disp_en_q;
    assign frame_tick = frame_tick_q;
    assign value_ack  = value_ack_q;
    assign busy       = pending_q;

endmodule

// File: tb/tb_display_scan_timer.sv
// Directed bench for display_scan_timer: TICKS_PER_DIGIT=10, BLANK_CYCLES=2, so a frame is 40 cycles.
module tb_display_scan_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value_in;
    logic        value_load;
    logic [1:0]  count2;
    logic [15:0] count16;
    logic        disp_en;
    logic        frame_tick;
    logic        value_ack;
    logic        busy;
`ifdef DISPLAY_SCAN_DIM_EN
    logic [2:0]  brightness;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;   // clock edges since the last reset edge
    int ack_cnt     = 0;
    int ft_cnt      = 0;
    int dim_hi      = 10;  // end (exclusive) of the lit part of a slot

    logic [31:0] exp_q[$];

    display_scan_timer #(
        .CLK_HZ      (4000),
        .REFRESH_HZ  (100),
        .BLANK_CYCLES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .value_in  (value_in),
        .value_load(value_load),
`ifdef DISPLAY_SCAN_DIM_EN
        .brightness(brightness),
`endif
        .count2    (count2),
        .count16   (count16),
        .disp_en   (disp_en),
        .frame_tick(frame_tick),
        .value_ack (value_ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
        end
    endtask

    // Expected scan position derived from the edge count since reset.
    task automatic chk_scan();
        int t;
        t = n % 10;
        chk("count2", 32'(count2), 32'((n / 10) % 4));
        chk("disp_en", 32'(disp_en), 32'((t >= 2) && (t < dim_hi)));
        chk("frame_tick", 32'(frame_tick), 32'((n > 0) && (n % 40 == 0)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        if (value_ack) ack_cnt++;
        if (frame_tick) ft_cnt++;
        chk_scan();
    endtask

    task automatic run_to(input int target);
        while (n < target) step();
    endtask

    task automatic load(input logic [15:0] v);
        value_in   = v;
        value_load = 1'b1;
        step();
        value_load = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_count2"}, 32'(count2), 32'd0);
        chk({tag, "_count16"}, 32'(count16), 32'd0);
        chk({tag, "_disp_en"}, 32'(disp_en), 32'd0);
        chk({tag, "_frame_tick"}, 32'(frame_tick), 32'd0);
        chk({tag, "_value_ack"}, 32'(value_ack), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Pop the next committed value from the scoreboard and compare with count16.
    task automatic chk_commit(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            e = 32'hDEAD_0000;
        end else begin
            e = exp_q.pop_front();
        end
        chk(tag, 32'(count16), e);
        chk({tag, "_ack"}, 32'(value_ack), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        value_in   = 16'h0000;
        value_load = 1'b0;
`ifdef DISPLAY_SCAN_DIM_EN
        brightness = 3'd7;
`endif

        // 1: reset held 3 cycles, then release
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        n = 0;
        chk_scan();

        // 2: free run; two frame ticks by edge 99
        run_to(99);
        chk("frame_tick_count", 32'(ft_cnt), 32'd2);
        chk("no_ack_idle", 32'(ack_cnt), 32'd0);

        // 3: single load of BEEF at count2=1, tick 5
        run_to(135);
        load(16'hBEEF);
        exp_q.push_back(32'hBEEF);
        chk("t3_busy_set", 32'(busy), 32'd1);
        chk("t3_hold0", 32'(count16), 32'd0);
        chk("t3_no_ack", 32'(value_ack), 32'd0);
        run_to(159);
        chk("t3_pre_boundary", 32'(count16), 32'd0);
        chk("t3_busy_pre", 32'(busy), 32'd1);
        run_to(160);
        chk_commit("t3_commit");
        chk("t3_busy_clr", 32'(busy), 32'd0);
        step();
        chk("t3_ack_pulse", 32'(value_ack), 32'd0);
        chk("t3_stable", 32'(count16), 32'hBEEF);

        // 4: two loads in one frame, latest wins, one ack
        ack_cnt = 0;
        load(16'h1234);
        chk("t4_busy", 32'(busy), 32'd1);
        run_to(180);
        load(16'h5678);
        exp_q.push_back(32'h5678);
        run_to(199);
        chk("t4_pre_boundary", 32'(count16), 32'hBEEF);
        run_to(200);
        chk_commit("t4_commit");
        run_to(230);
        chk("t4_one_ack", 32'(ack_cnt), 32'd1);
        chk("t4_busy_clr", 32'(busy), 32'd0);

        // 5: load on the boundary cycle while another value is pending
        load(16'hABCD);
        exp_q.push_back(32'hABCD);
        run_to(239);
        load(16'h0F0F);
        exp_q.push_back(32'h0F0F);
        chk_commit("t5_commit_old");
        chk("t5_busy_stays", 32'(busy), 32'd1);
        run_to(279);
        chk("t5_hold_old", 32'(count16), 32'hABCD);
        run_to(280);
        chk_commit("t5_commit_new");
        chk("t5_busy_clr", 32'(busy), 32'd0);
        chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: pending value discarded by a mid-frame reset
        load(16'h5A5A);
        chk("t6_busy", 32'(busy), 32'd1);
        run_to(300);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_all_zero("reset_mid");
        reset   = 1'b0;
        n       = 0;
        ack_cnt = 0;
`ifdef DISPLAY_SCAN_DIM_EN
        brightness = 3'd3;
`endif
        chk_scan();
        run_to(40);
        chk("t6_no_commit", 32'(count16), 32'd0);
        chk("t6_no_ack", 32'(value_ack), 32'd0);
`ifdef DISPLAY_SCAN_DIM_EN
        dim_hi = 6;
`endif
        run_to(60);
        chk("t6_ack_count", 32'(ack_cnt), 32'd0);
        chk("t6_busy_clr", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
